// File: rtl/imem_responder_if.sv
// Fetch request/response and program-load signal bundle for imem_responder.
interface imem_responder_if #(
   parameter int AW = 6,
   parameter int DW = 32
);
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] rsp_addr;
   logic          rsp_ready;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;

   modport master (
      output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
      input  req_ready, rsp_valid, rsp_data, rsp_addr
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_data,
      output req_ready, rsp_valid, rsp_data, rsp_addr
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with 1-cycle fetch latency into a 2-entry response FIFO.
module imem_responder #(
   parameter int AW    = 6,
   parameter int DW    = 32,
   parameter int DEPTH = 2**AW
) (
   input  logic             clk,
   input  logic             reset,
   imem_responder_if.slave  bus
);
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   logic [DW-1:0] mem [DEPTH];
   ent_t          slot [2];
   ent_t          last_q;
   ent_t          head;
   logic          wptr, rptr;
   logic [1:0]    count;
   logic          push, pop;

   // Gating with reset keeps req_ready low while held in reset even though count=0.
   assign bus.req_ready = reset && (count != 2'd2);
   assign bus.rsp_valid = (count != 2'd0);
   assign push          = bus.req_valid && bus.req_ready;
   assign pop           = bus.rsp_valid && bus.rsp_ready;

   // When empty, show the last popped entry so outputs hold their final value.
   assign head         = (count != 2'd0) ? slot[rptr] : last_q;
   assign bus.rsp_data = head.data;
   assign bus.rsp_addr = head.addr;

   // Storage array is intentionally not reset; a same-edge write is not seen by the read.
   always_ff @(posedge clk) begin
      if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot[0] <= '0;
         slot[1] <= '0;
         last_q  <= '0;
         wptr    <= 1'b0;
         rptr    <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            slot[wptr] <= '{addr: bus.req_addr, data: mem[bus.req_addr]};
            wptr       <= ~wptr;
         end
         if (pop) begin
            last_q <= slot[rptr];
            rptr   <= ~rptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: load, backpressure, streaming, RDW, wrap, reset.
module tb_imem_responder;
   localparam int AW = 6;
   localparam int DW = 32;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   logic clk;
   logic reset;
   imem_responder_if #(.AW(AW), .DW(DW)) bus ();

   imem_responder #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   ent_t          sb[$];
   logic [DW-1:0] mdl [64];
   logic          s_rdy, s_vld, acc, pop;
   logic [DW-1:0] s_data;
   logic [AW-1:0] s_addr;
   ent_t          e;

   // Sample at negedge, record handshakes into the scoreboard, then pass the next posedge.
   task automatic tick();
      @(negedge clk);
      s_rdy  = bus.req_ready;
      s_vld  = bus.rsp_valid;
      s_data = bus.rsp_data;
      s_addr = bus.rsp_addr;
      acc    = bus.req_valid && s_rdy;
      pop    = s_vld && bus.rsp_ready;
      if (acc) sb.push_back('{addr: bus.req_addr, data: mdl[bus.req_addr]});
      if (bus.prog_we) mdl[bus.prog_addr] = bus.prog_data;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      bus.prog_we   = 1'b0;
   endtask

   task automatic prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
      tick();
      bus.prog_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
      #2;
      total++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_ctl rdy=%b vld=%b need 0 0", bus.req_ready, bus.rsp_valid);
      end
      total++;
      if (bus.rsp_data !== '0 || bus.rsp_addr !== '0) begin
         bad++; $display("FAIL reset_out data=%h addr=%0d need 0 0", bus.rsp_data, bus.rsp_addr);
      end
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.req_ready !== 1'b0) begin
         bad++; $display("FAIL reset_hold rdy=%b need 0", bus.req_ready);
      end
      #3 reset = 1'b1;
      #1;
      total++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_release rdy=%b vld=%b need 1 0", bus.req_ready, bus.rsp_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_load();
      for (int i = 0; i < 64; i++) prog(i[AW-1:0], 32'h1000_0000 + i * 32'h0101);
      prog(6'd0, 32'h2008_0005);
      prog(6'd1, 32'h8C09_0004);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1; bus.req_addr = 6'd0;
      tick();
      total++;
      if (!acc || s_vld !== 1'b0) begin
         bad++; $display("FAIL load_acc0 acc=%b vld=%b need 1 0", acc, s_vld);
      end
      bus.req_addr = 6'd1;
      tick();
      total++;
      if (s_vld !== 1'b1 || s_data !== 32'h2008_0005 || s_addr !== 6'd0) begin
         bad++; $display("FAIL load_rsp0 vld=%b data=%h addr=%0d need 1 20080005 0", s_vld, s_data, s_addr);
      end
      if (pop && sb.size() > 0) e = sb.pop_front();
      idle();
      tick();
      total++;
      if (s_vld !== 1'b1 || s_data !== 32'h8C09_0004 || s_addr !== 6'd1) begin
         bad++; $display("FAIL load_rsp1 vld=%b data=%h addr=%0d need 1 8c090004 1", s_vld, s_data, s_addr);
      end
      if (pop && sb.size() > 0) e = sb.pop_front();
      tick();
      total++;
      if (s_vld !== 1'b0 || s_data !== 32'h8C09_0004 || s_addr !== 6'd1 || sb.size() != 0) begin
         bad++; $display("FAIL load_empty vld=%b data=%h addr=%0d left=%0d need 0 8c090004 1 0", s_vld, s_data, s_addr, sb.size());
      end
   endtask

   task automatic test_backpressure();
      int got[$];
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_addr = 6'd3;
      tick();
      bus.req_addr = 6'd4;
      tick();
      bus.req_addr = 6'd5;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (s_rdy !== 1'b0 || acc || s_vld !== 1'b1 || s_data !== mdl[3] || s_addr !== 6'd3) begin
            bad++; $display("FAIL bp_stall%0d rdy=%b vld=%b data=%h addr=%0d need 0 1 %h 3", k, s_rdy, s_vld, s_data, s_addr, mdl[3]);
         end
      end
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 8 && got.size() < 3; k++) begin
         tick();
         if (acc) bus.req_valid = 1'b0;
         if (pop) begin
            got.push_back(int'(s_addr));
            total++;
            if (sb.size() == 0) begin
               bad++; $display("FAIL bp_extra addr=%0d need none", s_addr);
            end else begin
               e = sb.pop_front();
               if (s_data !== e.data || s_addr !== e.addr) begin
                  bad++; $display("FAIL bp_rsp data=%h addr=%0d need %h %0d", s_data, s_addr, e.data, e.addr);
               end
            end
         end
      end
      total++;
      if (got.size() != 3 || got[0] != 3 || got[1] != 4 || got[2] != 5) begin
         bad++; $display("FAIL bp_order got=%p need 3 4 5", got);
      end
      idle();
      tick();
   endtask

   task automatic test_stream();
      int dips = 0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_addr = 6'd20;
      tick();
      bus.rsp_ready = 1'b1;
      for (int a = 0; a < 10; a++) begin
         bus.req_addr = a[AW-1:0];
         tick();
         if (s_rdy !== 1'b1 || s_vld !== 1'b1 || !acc) dips++;
         if (pop) begin
            total++;
            e = sb.pop_front();
            if (s_data !== e.data || s_addr !== e.addr) begin
               bad++; $display("FAIL stream_rsp data=%h addr=%0d need %h %0d", s_data, s_addr, e.data, e.addr);
            end
         end
      end
      total++;
      if (dips != 0 || sb.size() != 1) begin
         bad++; $display("FAIL stream_flow dips=%0d pending=%0d need 0 1", dips, sb.size());
      end
      idle();
      tick();
      total++;
      e = sb.pop_front();
      if (!pop || s_addr !== 6'd9 || s_data !== e.data) begin
         bad++; $display("FAIL stream_last pop=%b addr=%0d data=%h need 1 9 %h", pop, s_addr, s_data, e.data);
      end
      tick();
   endtask

   task automatic test_rdw();
      prog(6'd7, 32'hAAAA_0000);
      bus.rsp_ready = 1'b1;
      bus.prog_we = 1'b1; bus.prog_addr = 6'd7; bus.prog_data = 32'h5555_FFFF;
      bus.req_valid = 1'b1; bus.req_addr = 6'd7;
      tick();
      idle();
      tick();
      total++;
      if (pop) e = sb.pop_front();
      if (!pop || s_data !== 32'hAAAA_0000 || e.data !== 32'hAAAA_0000) begin
         bad++; $display("FAIL rdw_old pop=%b data=%h need 1 aaaa0000", pop, s_data);
      end
      bus.req_valid = 1'b1; bus.req_addr = 6'd7;
      tick();
      idle();
      tick();
      total++;
      if (pop) e = sb.pop_front();
      if (!pop || s_data !== 32'h5555_FFFF || s_addr !== 6'd7) begin
         bad++; $display("FAIL rdw_new pop=%b data=%h addr=%0d need 1 5555ffff 7", pop, s_data, s_addr);
      end
   endtask

   task automatic test_wrap();
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1; bus.req_addr = 6'd63;
      tick();
      bus.req_addr = 6'd0;
      tick();
      total++;
      if (pop) e = sb.pop_front();
      if (!pop || s_addr !== 6'd63 || s_data !== mdl[63]) begin
         bad++; $display("FAIL wrap_63 pop=%b addr=%0d data=%h need 1 63 %h", pop, s_addr, s_data, mdl[63]);
      end
      idle();
      tick();
      total++;
      if (pop) e = sb.pop_front();
      if (!pop || s_addr !== 6'd0 || s_data !== 32'h2008_0005) begin
         bad++; $display("FAIL wrap_0 pop=%b addr=%0d data=%h need 1 0 20080005", pop, s_addr, s_data);
      end
   endtask

   task automatic test_reset_mid();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_addr = 6'd10;
      tick();
      bus.req_addr = 6'd11;
      tick();
      idle();
      total++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
         bad++; $display("FAIL mid_full rdy=%b vld=%b need 0 1", bus.req_ready, bus.rsp_valid);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) begin
         bad++; $display("FAIL mid_async rdy=%b vld=%b data=%h need 0 0 0", bus.req_ready, bus.rsp_valid, bus.rsp_data);
      end
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      bus.rsp_ready = 1'b1;
      tick();
      total++;
      if (s_vld !== 1'b0 || s_rdy !== 1'b1) begin
         bad++; $display("FAIL mid_flushed vld=%b rdy=%b need 0 1", s_vld, s_rdy);
      end
      bus.req_valid = 1'b1; bus.req_addr = 6'd10;
      tick();
      idle();
      tick();
      total++;
      if (pop) e = sb.pop_front();
      if (!pop || s_addr !== 6'd10 || s_data !== (32'h1000_0000 + 10 * 32'h0101)) begin
         bad++; $display("FAIL mid_array pop=%b addr=%0d data=%h need 1 10 %h", pop, s_addr, s_data, 32'h1000_0000 + 10 * 32'h0101);
      end
      tick();
      total++;
      if (s_vld !== 1'b0 || sb.size() != 0) begin
         bad++; $display("FAIL mid_drain vld=%b left=%0d need 0 0", s_vld, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_backpressure();
      test_stream();
      test_rdw();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
